// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : mem_bus_arbiter
// Brief   : Shares one memory bus between CPU port C and block engine port D.
// Revision: 1.0
// ============================================================================
module mem_bus_arbiter #(
  parameter int ADDR_W    = 11,
  parameter int RD_LAT    = 1,
  parameter int MAX_WAIT  = 8,
  parameter int BURST_MAX = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              c_req_i,
  input  logic [3:0]        c_we_i,
  input  logic [ADDR_W-1:0] c_addr_i,
  input  logic [31:0]       c_wdata_i,
  output logic              c_gnt_o,
  output logic              c_stall_o,
  output logic              c_rvalid_o,
  output logic [31:0]       c_rdata_o,
  input  logic              d_req_i,
  input  logic              d_lock_i,
  input  logic [3:0]        d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [31:0]       d_wdata_i,
  output logic              d_gnt_o,
  output logic              d_rvalid_o,
  output logic [31:0]       d_rdata_o,
  output logic              mem_en_o,
  output logic [3:0]        mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i
);

  localparam int c_WAIT_W = $clog2(MAX_WAIT + 1);
  localparam int c_BEAT_W = $clog2(BURST_MAX + 1);

  typedef enum logic [0:0] {
    ST_ARB   = 1'b0,
    ST_BURST = 1'b1
  } state_e;

  state_e              state_q;
  logic [c_WAIT_W-1:0] wait_q, wait_d;
  logic [c_BEAT_W-1:0] beat_q;
  logic [c_BEAT_W-1:0] w_beat_inc;
  logic [RD_LAT-1:0]   vld_q, own_q;

  logic w_starve, w_c_gnt, w_d_gnt, w_push;

  assign w_starve   = d_req_i & (wait_q == c_WAIT_W'(MAX_WAIT));
  assign w_beat_inc = beat_q + c_BEAT_W'(1);

  always_comb begin
    w_c_gnt = 1'b0;
    w_d_gnt = 1'b0;
    if (state_q == ST_BURST) begin
      w_d_gnt = d_req_i;
    end else begin
      w_c_gnt = c_req_i & ~w_starve;
      w_d_gnt = ~w_c_gnt & d_req_i;
    end
  end

  always_comb begin
    wait_d = wait_q;
    if (w_d_gnt || !d_req_i) begin
      wait_d = '0;
    end else if (wait_q != c_WAIT_W'(MAX_WAIT)) begin
      wait_d = wait_q + c_WAIT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ARB;
      beat_q  <= '0;
      wait_q  <= '0;
    end else begin
      wait_q <= wait_d;
      case (state_q)
        ST_ARB: begin
          if (w_d_gnt && d_lock_i && (BURST_MAX > 1)) begin
            state_q <= ST_BURST;
            beat_q  <= c_BEAT_W'(1);
          end
        end
        ST_BURST: begin
          if (w_d_gnt) begin
            beat_q <= w_beat_inc;
          end
          // The beat that reaches the limit is still granted; the bus is released after it.
          if (!d_lock_i || !d_req_i || (w_d_gnt && (w_beat_inc == c_BEAT_W'(BURST_MAX)))) begin
            state_q <= ST_ARB;
            beat_q  <= '0;
          end
        end
        default: begin
          state_q <= ST_ARB;
          beat_q  <= '0;
        end
      endcase
    end
  end

  assign w_push = (w_c_gnt & (c_we_i == 4'b0000)) | (w_d_gnt & (d_we_i == 4'b0000));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      own_q <= '0;
    end else begin
      vld_q[0] <= w_push;
      own_q[0] <= w_d_gnt;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        own_q[i] <= own_q[i-1];
      end
    end
  end

  // Outputs are forced low while reset is held, independent of requester inputs.
  assign c_gnt_o    = rst_n & w_c_gnt;
  assign d_gnt_o    = rst_n & w_d_gnt;
  assign c_stall_o  = rst_n & c_req_i & ~w_c_gnt;
  assign c_rvalid_o = vld_q[RD_LAT-1] & ~own_q[RD_LAT-1];
  assign d_rvalid_o = vld_q[RD_LAT-1] &  own_q[RD_LAT-1];
  assign c_rdata_o  = rst_n ? mem_rdata_i : 32'h0;
  assign d_rdata_o  = rst_n ? mem_rdata_i : 32'h0;

  always_comb begin
    mem_en_o    = 1'b0;
    mem_we_o    = 4'b0000;
    mem_addr_o  = '0;
    mem_wdata_o = 32'h0;
    if (c_gnt_o) begin
      mem_en_o    = 1'b1;
      mem_we_o    = c_we_i;
      mem_addr_o  = c_addr_i;
      mem_wdata_o = c_wdata_i;
    end else if (d_gnt_o) begin
      mem_en_o    = 1'b1;
      mem_we_o    = d_we_i;
      mem_addr_o  = d_addr_i;
      mem_wdata_o = d_wdata_i;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_bus_arbiter
// Brief   : Directed bench for mem_bus_arbiter with a read-return scoreboard.
// Revision: 1.0
// ============================================================================
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        c_req, d_req, d_lock;
  logic [3:0]  c_we, d_we;
  logic [10:0] c_addr, d_addr;
  logic [31:0] c_wdata, d_wdata;
  logic        c_gnt, c_stall, c_rvalid, d_gnt, d_rvalid, mem_en;
  logic [31:0] c_rdata, d_rdata, mem_wdata, mem_rdata;
  logic [3:0]  mem_we;
  logic [10:0] mem_addr;

  logic        c_gnt2, c_stall2, c_rvalid2, d_gnt2, d_rvalid2, mem_en2;
  logic [31:0] c_rdata2, d_rdata2, mem_wdata2;
  logic [3:0]  mem_we2;
  logic [10:0] mem_addr2;

  typedef struct packed { logic own; logic [31:0] data; } exp_t;
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   rv_seen = 0;
  logic watch = 1'b0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.ADDR_W(11), .RD_LAT(1), .MAX_WAIT(8), .BURST_MAX(16)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .c_req_i(c_req), .c_we_i(c_we), .c_addr_i(c_addr), .c_wdata_i(c_wdata),
    .c_gnt_o(c_gnt), .c_stall_o(c_stall), .c_rvalid_o(c_rvalid), .c_rdata_o(c_rdata),
    .d_req_i(d_req), .d_lock_i(d_lock), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
    .d_gnt_o(d_gnt), .d_rvalid_o(d_rvalid), .d_rdata_o(d_rdata),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata)
  );

  mem_bus_arbiter #(.ADDR_W(11), .RD_LAT(2), .MAX_WAIT(8), .BURST_MAX(16)) u_dut2 (
    .clk(clk), .rst_n(rst_n),
    .c_req_i(c_req), .c_we_i(c_we), .c_addr_i(c_addr), .c_wdata_i(c_wdata),
    .c_gnt_o(c_gnt2), .c_stall_o(c_stall2), .c_rvalid_o(c_rvalid2), .c_rdata_o(c_rdata2),
    .d_req_i(d_req), .d_lock_i(d_lock), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
    .d_gnt_o(d_gnt2), .d_rvalid_o(d_rvalid2), .d_rdata_o(d_rdata2),
    .mem_en_o(mem_en2), .mem_we_o(mem_we2), .mem_addr_o(mem_addr2), .mem_wdata_o(mem_wdata2),
    .mem_rdata_i(32'h0)
  );

  // Memory model: one-cycle read latency, content is a fixed function of the address.
  always @(posedge clk) begin
    if (mem_en && mem_we == 4'b0000)
      mem_rdata <= (mem_addr == 11'h010) ? 32'hDEADBEEF : (32'hC0DE0000 | {21'h0, mem_addr});
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (watch && (c_rvalid || d_rvalid || c_rvalid2 || d_rvalid2)) rv_seen++;
    if (c_rvalid || d_rvalid) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL rd_unexpected: got c_rvalid=%b d_rvalid=%b expected none", c_rvalid, d_rvalid);
      end else begin
        exp_t e;
        logic [31:0] got;
        e   = sb.pop_front();
        got = c_rvalid ? c_rdata : d_rdata;
        if ((c_rvalid && d_rvalid) || (d_rvalid != e.own) || (got !== e.data)) begin
          n_bad++;
          $display("FAIL rd_return: got c_rv=%b d_rv=%b data=%h expected owner_d=%b data=%h",
                   c_rvalid, d_rvalid, got, e.own, e.data);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; c_req = 1'b1; d_req = 1'b1; d_lock = 1'b0;
    c_we = 4'hF; d_we = 4'hF; c_addr = 11'h123; d_addr = 11'h456;
    c_wdata = 32'h1; d_wdata = 32'h2;

    // Reset: outputs low despite requests
    tick(); tick();
    @(negedge clk);
    chk("rst_c_gnt", c_gnt, 0);   chk("rst_d_gnt", d_gnt, 0);
    chk("rst_c_stall", c_stall, 0); chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_addr", mem_addr, 0); chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_c_rdata", c_rdata, 0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_c_gnt", c_gnt, 1); chk("rel_d_gnt", d_gnt, 0);
    tick();
    c_req = 1'b0; d_req = 1'b0;
    tick();

    // C read
    c_req = 1'b1; c_we = 4'h0; c_addr = 11'h010;
    sb.push_back('{own: 1'b0, data: 32'hDEADBEEF});
    @(negedge clk);
    chk("crd_gnt", c_gnt, 1); chk("crd_en", mem_en, 1);
    chk("crd_we", mem_we, 0); chk("crd_addr", mem_addr, 11'h010);
    tick();
    c_req = 1'b0;
    tick();

    // Back-to-back C reads then a D read
    c_req = 1'b1; c_addr = 11'h010;
    sb.push_back('{own: 1'b0, data: 32'hDEADBEEF});
    tick();
    c_addr = 11'h020;
    sb.push_back('{own: 1'b0, data: 32'hC0DE0020});
    tick();
    c_req = 1'b0; d_req = 1'b1; d_we = 4'h0; d_addr = 11'h025;
    sb.push_back('{own: 1'b1, data: 32'hC0DE0025});
    @(negedge clk);
    chk("drd_gnt", d_gnt, 1); chk("drd_addr", mem_addr, 11'h025);
    tick();
    d_req = 1'b0;
    tick();

    // Starvation guard
    c_req = 1'b1; c_we = 4'hF; c_addr = 11'h030; c_wdata = 32'hA5A50030;
    d_req = 1'b1; d_we = 4'b0011; d_addr = 11'h040; d_wdata = 32'h5A5A0040;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      chk($sformatf("starve_c_gnt%0d", k), c_gnt, (k != 9));
      chk($sformatf("starve_d_gnt%0d", k), d_gnt, (k == 9));
      chk($sformatf("starve_stall%0d", k), c_stall, (k == 9));
      if (k == 8) chk("starve_addr_c", mem_addr, 11'h030);
      if (k == 9) begin
        chk("starve_addr_d", mem_addr, 11'h040);
        chk("starve_we_d", mem_we, 4'b0011);
        chk("starve_wdata_d", mem_wdata, 32'h5A5A0040);
      end
      tick();
    end
    c_req = 1'b0; d_req = 1'b0;
    tick();

    // Locked burst, C raised mid-burst
    d_req = 1'b1; d_lock = 1'b1; d_we = 4'hF; d_addr = 11'h100; d_wdata = 32'h0000B00B;
    c_addr = 11'h101;
    for (int k = 1; k <= 20; k++) begin
      if (k == 5) c_req = 1'b1;
      @(negedge clk);
      chk($sformatf("burst_d_gnt%0d", k), d_gnt, (k <= 16));
      chk($sformatf("burst_c_gnt%0d", k), c_gnt, (k >= 17));
      chk($sformatf("burst_stall%0d", k), c_stall, (k >= 5 && k <= 16));
      tick();
    end
    c_req = 1'b0; d_req = 1'b0; d_lock = 1'b0;
    tick();

    // Locked burst with C idle: beat 17 goes to D
    d_req = 1'b1; d_lock = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      chk($sformatf("burst2_d_gnt%0d", k), d_gnt, 1);
      tick();
    end
    d_req = 1'b0; d_lock = 1'b0;
    tick();

    // Burst of 4 ended by dropping lock, C pending
    d_req = 1'b1; d_lock = 1'b1; d_addr = 11'h200;
    for (int k = 1; k <= 5; k++) begin
      if (k == 2) begin c_req = 1'b1; c_addr = 11'h300; end
      if (k == 4) d_lock = 1'b0;
      @(negedge clk);
      chk($sformatf("unlock_d_gnt%0d", k), d_gnt, (k <= 4));
      chk($sformatf("unlock_c_gnt%0d", k), c_gnt, (k == 5));
      tick();
    end
    c_req = 1'b0; d_req = 1'b0;
    tick();

    // Reset with a read in flight
    c_req = 1'b1; c_we = 4'h0; c_addr = 11'h010;
    @(negedge clk);
    chk("rflush_c_gnt", c_gnt, 1); chk("rflush_c_gnt2", c_gnt2, 1);
    tick();
    rst_n = 1'b0; c_req = 1'b0; watch = 1'b1;
    @(negedge clk);
    chk("rflush_mem_en2", mem_en2, 0);
    tick(); tick();
    rst_n = 1'b1; c_req = 1'b1; d_req = 1'b1; c_we = 4'hF; d_we = 4'hF;
    @(negedge clk);
    chk("rflush_c_gnt_rel", c_gnt, 1);  chk("rflush_d_gnt_rel", d_gnt, 0);
    chk("rflush_c_gnt2_rel", c_gnt2, 1); chk("rflush_d_gnt2_rel", d_gnt2, 0);
    tick();
    c_req = 1'b0; d_req = 1'b0;
    tick(); tick();
    watch = 1'b0;
    chk("rflush_no_rvalid", rv_seen, 0);
    chk("sb_drain", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
